digit_serial_addsub: RTL and testbench



---
 rtl/serial_arith_pkg.sv | 16 +
 rtl/digit_adder.sv | 28 ++
 rtl/digit_serial_addsub.sv | 124 ++++++++++++
 tb/tb_digit_serial_addsub.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the serial arithmetic blocks.
//   state_e    : packet framing state (IDLE between packets, BUSY inside one)
//   cnt_width  : width of a digit counter that saturates at max_digits+1
package serial_arith_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // The counter must hold 0 .. max_digits+1, so size it for max_digits+2 codes.
    function automatic int cnt_width(input int max_digits);
        return $clog2(max_digits + 2);
    endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT_W-bit adder slice for the digit-serial add/subtract path.
//   a, b_eff : operand digits (b_eff is already inverted for subtract)
//   cin      : carry into the LSB
//   d        : sum digit
//   cout     : carry out of the MSB
//   a_msb, b_msb, d_msb : sign bits used by the signed-overflow check
module digit_adder
    import serial_arith_pkg::*;
#(
    parameter int DIGIT_W = 1
) (
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b_eff,
    input  logic               cin,
    output logic [DIGIT_W-1:0] d,
    output logic               cout,
    output logic               a_msb,
    output logic               b_msb,
    output logic               d_msb
);

    assign {cout, d} = {1'b0, a} + {1'b0, b_eff} + {{DIGIT_W{1'b0}}, cin};

    assign a_msb = a[DIGIT_W-1];
    assign b_msb = b_eff[DIGIT_W-1];
    assign d_msb = d[DIGIT_W-1];

endmodule

// File: rtl/digit_serial_addsub.sv
// Digit-serial adder/subtractor, DIGIT_W bits per beat, LS digit first.
// One-cycle registered latency, no backpressure.
//   clk, rst          : clock, asynchronous active-low reset
//   in_vld, in_last   : input beat framing (in_last qualified by in_vld)
//   sub               : 0 = a+b, 1 = a-b; taken from the first beat only
//   a, b              : operand digits
//   out_vld, out_last : result beat framing
//   sum               : result digit (0 when out_vld=0)
//   carry_out, ovf, len_err : end-of-packet status, nonzero only with out_last
//
// state | meaning
// IDLE  | between packets; next valid beat is a first digit
// BUSY  | inside a packet; mode and carry come from registers
module digit_serial_addsub
    import serial_arith_pkg::*;
#(
    parameter int DIGIT_W    = 1,
    parameter int MAX_DIGITS = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_vld,
    input  logic               in_last,
    input  logic               sub,
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    output logic               out_vld,
    output logic               out_last,
    output logic [DIGIT_W-1:0] sum,
    output logic               carry_out,
    output logic               ovf,
    output logic               len_err
);

    localparam int               CNT_W   = cnt_width(MAX_DIGITS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_DIGITS + 1);

    state_e             state_q;
    logic               carry_q;
    logic               mode_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               err_q;

    logic               first;
    logic               m_eff;
    logic               c_in;
    logic [DIGIT_W-1:0] b_eff;
    logic [DIGIT_W-1:0] d;
    logic               c_next;
    logic               a_msb;
    logic               b_msb;
    logic               d_msb;
    logic               ovf_now;
    logic [CNT_W-1:0]   cnt_base;
    logic [CNT_W-1:0]   cnt_next;
    logic               err_now;

    // On a first beat the stored carry/mode/count belong to no packet, so they
    // are bypassed; this is what lets back-to-back packets run without a bubble.
    always_comb begin
        first    = (state_q == IDLE);
        m_eff    = first ? sub : mode_q;
        c_in     = first ? sub : carry_q;
        b_eff    = m_eff ? ~b : b;
        cnt_base = first ? '0 : cnt_q;
        cnt_next = (cnt_base == CNT_SAT) ? CNT_SAT : cnt_base + CNT_W'(1);
        err_now  = (first ? 1'b0 : err_q) | (cnt_base == CNT_MAX);
        ovf_now  = (a_msb == b_msb) && (d_msb != a_msb);
    end

    digit_adder #(
        .DIGIT_W (DIGIT_W)
    ) u_digit_adder (
        .a     (a),
        .b_eff (b_eff),
        .cin   (c_in),
        .d     (d),
        .cout  (c_next),
        .a_msb (a_msb),
        .b_msb (b_msb),
        .d_msb (d_msb)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            carry_q   <= 1'b0;
            mode_q    <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            out_vld   <= 1'b0;
            out_last  <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            ovf       <= 1'b0;
            len_err   <= 1'b0;
        end else begin
            out_vld   <= in_vld;
            out_last  <= in_vld & in_last;
            sum       <= in_vld ? d : '0;
            carry_out <= in_vld & in_last & c_next;
            ovf       <= in_vld & in_last & ovf_now;
            len_err   <= in_vld & in_last & err_now;

            if (in_vld) begin
                if (in_last) begin
                    state_q <= IDLE;
                    carry_q <= 1'b0;
                    mode_q  <= 1'b0;
                    cnt_q   <= '0;
                    err_q   <= 1'b0;
                end else begin
                    state_q <= BUSY;
                    carry_q <= c_next;
                    mode_q  <= m_eff;
                    cnt_q   <= cnt_next;
                    err_q   <= err_now;
                end
            end
        end
    end

endmodule

// File: tb/tb_digit_serial_addsub.sv
module tb_digit_serial_addsub;

    logic       clk;
    logic       rst;
    logic       in_vld;
    logic       in_last;
    logic       sub;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_vld;
    logic       out_last;
    logic [3:0] sum;
    logic       carry_out;
    logic       ovf;
    logic       len_err;

    int n_checks;
    int n_pass;

    digit_serial_addsub #(
        .DIGIT_W    (4),
        .MAX_DIGITS (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_vld    (in_vld),
        .in_last   (in_last),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .out_vld   (out_vld),
        .out_last  (out_last),
        .sum       (sum),
        .carry_out (carry_out),
        .ovf       (ovf),
        .len_err   (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed/expected are packed as {out_vld, out_last, sum[3:0], carry_out, ovf, len_err}.
    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got vld/last/sum/c/ovf/err=%b/%b/%h/%b/%b/%b expected %b/%b/%h/%b/%b/%b",
                      tag, got[8], got[7], got[6:3], got[2], got[1], got[0],
                      exp[8], exp[7], exp[6:3], exp[2], exp[1], exp[0]);
    endtask

    function automatic logic [8:0] obs();
        return {out_vld, out_last, sum, carry_out, ovf, len_err};
    endfunction

    // Drive one valid beat, clock it, and check the registered result.
    task automatic beat(input string tag, input logic [3:0] av, input logic [3:0] bv,
                        input logic s, input logic l, input logic [3:0] es,
                        input logic ec, input logic eo, input logic ee);
        in_vld  = 1'b1;
        in_last = l;
        sub     = s;
        a       = av;
        b       = bv;
        @(posedge clk);
        #1;
        check(tag, obs(), {1'b1, l, es, ec, eo, ee});
    endtask

    // Idle cycle with arbitrary in_last; output must be all-zero.
    task automatic gap(input string tag, input logic l);
        in_vld  = 1'b0;
        in_last = l;
        a       = 4'hA;
        b       = 4'h5;
        @(posedge clk);
        #1;
        check(tag, obs(), 9'b0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b0;
        in_vld   = 1'b0;
        in_last  = 1'b0;
        sub      = 1'b0;
        a        = 4'h0;
        b        = 4'h0;

        #12;
        check("reset", obs(), 9'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // 0x1234 + 0x0FCD = 0x2201
        beat("add0", 4'h4, 4'hD, 1'b0, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0);
        beat("add1", 4'h3, 4'hC, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        beat("add2", 4'h2, 4'hF, 1'b0, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0);
        beat("add3", 4'h1, 4'h0, 1'b0, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0);
        gap("idle0", 1'b0);

        // 0x05 - 0x07 = 0xFE with borrow; sub dropped on beat 2 must not matter
        beat("sub0", 4'h5, 4'h7, 1'b1, 1'b0, 4'hE, 1'b0, 1'b0, 1'b0);
        beat("sub1", 4'h0, 4'h0, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0);

        // 0x7F + 0x01 = 0x80, signed overflow
        beat("ovfa0", 4'hF, 4'h1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        beat("ovfa1", 4'h7, 4'h0, 1'b0, 1'b1, 4'h8, 1'b0, 1'b1, 1'b0);
        // 0x80 - 0x01 = 0x7F, signed overflow, no borrow
        beat("ovfs0", 4'h0, 4'h1, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
        beat("ovfs1", 4'h8, 4'h0, 1'b1, 1'b1, 4'h7, 1'b1, 1'b1, 1'b0);
        gap("idle1", 1'b0);

        // add case again with gaps; in_last during a gap must not end the packet
        beat("gadd0", 4'h4, 4'hD, 1'b0, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0);
        gap("gap0", 1'b0);
        beat("gadd1", 4'h3, 4'hC, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        gap("gap1", 1'b1);
        gap("gap2", 1'b1);
        beat("gadd2", 4'h2, 4'hF, 1'b0, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0);
        gap("gap3", 1'b0);
        beat("gadd3", 4'h1, 4'h0, 1'b0, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0);

        // back-to-back: single-beat F+1, then 0x03 - 0x01 with no bubble
        beat("b2b0", 4'hF, 4'h1, 1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0);
        beat("b2b1", 4'h3, 4'h1, 1'b1, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0);
        beat("b2b2", 4'h0, 4'h0, 1'b1, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0);

        // 5-beat packet with MAX_DIGITS=4: len_err only on the last output
        beat("len0", 4'h1, 4'h1, 1'b0, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0);
        beat("len1", 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        beat("len2", 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        beat("len3", 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        beat("len4", 4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1);
        // next packet must start with the error cleared
        beat("len_clr", 4'h2, 4'h3, 1'b0, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0);

        // reset mid-packet: two beats leave carry=1 inside the DUT
        beat("rst0", 4'h4, 4'hD, 1'b0, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0);
        beat("rst1", 4'h3, 4'hC, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        in_vld = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("rst_async", obs(), 9'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        // 0x11 + 0x22 = 0x33, aborted packet's carry must not leak in
        beat("post0", 4'h1, 4'h2, 1'b0, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0);
        beat("post1", 4'h1, 4'h2, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
        gap("idle2", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
